io_bus_controller: RTL and testbench
====================================

# io_bus_controller

Initiator side of the on-chip I/O bus. Accepts single-word CPU load/store requests aimed at the I/O window. Decodes the address into a device number and a 4-bit register offset, drives the one-cycle device strobes, captures the selected device's read data and returns it to the CPU with a completion pulse. Sits between the CPU memory stage and all I/O devices. Devices are allocated top-down: device 0 is the simple I/O device at 0xFFF0–0xFFFF.

## Interface
Parameters:
- NUM_DEVICES, 4: number of attached devices, 1..16. Device k occupies 16-word window number 2047−k, so its base address is 0xFFF0 − 16·k.
- IO_BASE, 16'h8000: lowest I/O address. The I/O window is IO_BASE..0xFFFF.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  word address
- cpu_wdata  in  16  write data
- cpu_ready  out  1  controller can accept a request
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data; valid while cpu_done is high
- cpu_err  out  1  bus error; valid while cpu_done is high
- device_select  out  NUM_DEVICES  one-hot device select
- register_offset  out  4  register within device
- read_req  out  1  read strobe
- write_req  out  1  write strobe
- wdata  out  16  write data to devices
- dev_rdata  in  16·NUM_DEVICES  device k's read data in bits [16k+15:16k]
- err_count  out  16  saturating bus-error counter
- last_err_addr  out  16  address of the most recent errored access

## Operation
- Three-state FSM: IDLE, ISSUE, RESP.
- IDLE:
  - cpu_ready=1.
  - On cpu_req, register cpu_we, cpu_addr and cpu_wdata, then go to ISSUE.
- ISSUE:
  - cpu_ready=0.
  - Drive register_offset=addr[3:0] and wdata=registered wdata.
  - Device hit: addr ≥ IO_BASE and k = 2047 − addr[14:4] < NUM_DEVICES.
    - device_select = one-hot k.
    - read_req = !we; write_req = we.
  - Miss (below IO_BASE, or k ≥ NUM_DEVICES): device_select=0, read_req=0, write_req=0.
  - Sample the hit device's dev_rdata slice at the end of the cycle, then go to RESP.
- RESP:
  - cpu_done=1 and cpu_ready=0.
  - Read hit: cpu_rdata = sampled data, cpu_err=0.
  - Write hit: cpu_rdata = 0x0000, cpu_err=0.
  - Miss, read or write: cpu_rdata = 0xFFFF (bus pull-ups), cpu_err=1.
    - err_count increments and saturates at 0xFFFF.
    - last_err_addr is loaded with the request address.
  - Go to IDLE.
- When not in ISSUE: device_select=0, read_req=0, write_req=0; register_offset and wdata hold their last values.
- Outside RESP, cpu_rdata and cpu_err are 0.
- cpu_req while cpu_ready=0 is ignored. It is not queued; the CPU must hold the request until it is accepted.

## Timing
- Accept at cycle N (cpu_req && cpu_ready).
- Strobes are registered outputs, high for exactly cycle N+1.
- cpu_done is high in cycle N+2.
- The next accept is possible at N+3. Throughput is one access per 3 cycles.
- Read data is sampled once, at the N+1 edge. Later changes in dev_rdata do not affect cpu_rdata.
- Reset values: state=IDLE, cpu_ready=1, every other output 0 (including err_count and last_err_addr).
- Reset mid-transaction (ISSUE or RESP): the access is dropped, no cpu_done is produced, outputs return to reset values the next cycle, and err_count is not updated.
- cpu_req asserted in the same cycle reset deasserts: not accepted. The accept is evaluated only when reset=0.

## Structure
- Package io_bus_pkg holds:
  - IO_WINDOW_WORDS=16
  - TOP_DEVICE_NUM=2047
  - ERR_READ_DATA=16'hFFFF
  - the state enum io_state_t {IDLE, ISSUE, RESP}
  - function dev_index(addr), returning 2047 − addr[14:4]
- Sub-module io_addr_decoder (combinational):
  - Inputs: addr and NUM_DEVICES.
  - Outputs: hit, one-hot select, offset.
  - Instantiated once on the registered request address.

## Test plan
- Read 0xFFFE with dev_rdata[15:0]=0xA5A5:
  - N+1: device_select=0001, register_offset=0xE, read_req=1.
  - N+2: cpu_done=1, cpu_rdata=0xA5A5, cpu_err=0.
- Write 0x1234 to 0xFFFF: in N+1, write_req=1, wdata=0x1234, register_offset=0xF, device_select=0001. Then cpu_done with cpu_err=0 and cpu_rdata=0x0000.
- Read 0xFFD3 with NUM_DEVICES=4: device_select=0100, register_offset=0x3, data taken from slice 2.
- Read 0xF000 (unmapped):
  - No strobes.
  - cpu_rdata=0xFFFF, cpu_err=1.
  - err_count=1, last_err_addr=0xF000.
- Write 0x1234 (address below IO_BASE): error response, err_count increments.
- Back-to-back and reset:
  - Hold cpu_req high for 6 cycles: exactly two accepts, at N and N+3.
  - Assert reset during ISSUE: no cpu_done, all outputs at reset values, err_count unchanged.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared constants, state encoding and address helpers for the I/O bus initiator.
package io_bus_pkg;

  localparam int          IO_WINDOW_WORDS = 16;
  localparam int          TOP_DEVICE_NUM  = 2047;
  localparam logic [15:0] ERR_READ_DATA   = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } io_state_t;

  // Devices are allocated top-down, so window 2047 is device 0.
  function automatic logic [10:0] dev_index(input logic [15:0] addr);
    return 11'(TOP_DEVICE_NUM) - addr[14:4];
  endfunction

endpackage

// File: rtl/io_addr_decoder.sv
// Combinational decode of a word address into device hit, one-hot select and register offset.
module io_addr_decoder
  import io_bus_pkg::*;
#(
  parameter int          NUM_DEVICES = 4,
  parameter logic [15:0] IO_BASE     = 16'h8000
) (
  input  logic [15:0]            addr,
  output logic                   hit,
  output logic [NUM_DEVICES-1:0] select,
  output logic [3:0]             offset
);

  localparam int OFF_W = $clog2(IO_WINDOW_WORDS);

  logic [10:0] idx;

  always_comb begin
    idx    = dev_index(addr);
    hit    = (addr >= IO_BASE) && ({1'b0, idx} < 12'(NUM_DEVICES));
    select = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      select[i] = hit && (idx == 11'(i));
    end
    offset = addr[OFF_W-1:0];
  end

endmodule

// File: rtl/io_bus_controller.sv
// I/O bus initiator: one CPU access per three cycles (accept, strobe, respond).
// Handshake: a request transfers on a rising edge where cpu_req && cpu_ready; cpu_done pulses two cycles later.
module io_bus_controller
  import io_bus_pkg::*;
#(
  parameter int          NUM_DEVICES = 4,
  parameter logic [15:0] IO_BASE     = 16'h8000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [15:0]               cpu_addr,
  input  logic [15:0]               cpu_wdata,
  output logic                      cpu_ready,
  output logic                      cpu_done,
  output logic [15:0]               cpu_rdata,
  output logic                      cpu_err,
  output logic [NUM_DEVICES-1:0]    device_select,
  output logic [3:0]                register_offset,
  output logic                      read_req,
  output logic                      write_req,
  output logic [15:0]               wdata,
  input  logic [16*NUM_DEVICES-1:0] dev_rdata,
  output logic [15:0]               err_count,
  output logic [15:0]               last_err_addr
);

  io_state_t   state_q, state_d;
  logic        req_we_q, req_we_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] req_wdata_q, req_wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] last_err_addr_q, last_err_addr_d;

  logic                   dec_hit;
  logic [NUM_DEVICES-1:0] dec_select;
  logic [3:0]             dec_offset;

  io_addr_decoder #(
    .NUM_DEVICES(NUM_DEVICES),
    .IO_BASE    (IO_BASE)
  ) u_decoder (
    .addr  (req_addr_q),
    .hit   (dec_hit),
    .select(dec_select),
    .offset(dec_offset)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_we_d        = req_we_q;
    req_addr_d      = req_addr_q;
    req_wdata_d     = req_wdata_q;
    rdata_d         = rdata_q;
    err_count_d     = err_count_q;
    last_err_addr_d = last_err_addr_q;
    if (state_q == IDLE && cpu_req) begin
      req_we_d    = cpu_we;
      req_addr_d  = cpu_addr;
      req_wdata_d = cpu_wdata;
    end
    // Read data is captured once, at the end of the strobe cycle.
    if (state_q == ISSUE) begin
      rdata_d = '0;
      for (int i = 0; i < NUM_DEVICES; i++) begin
        if (dec_select[i]) rdata_d = dev_rdata[16*i +: 16];
      end
    end
    if (state_q == RESP && !dec_hit) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      last_err_addr_d = req_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_we_q        <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      rdata_q         <= '0;
      err_count_q     <= '0;
      last_err_addr_q <= '0;
    end else begin
      req_we_q        <= req_we_d;
      req_addr_q      <= req_addr_d;
      req_wdata_q     <= req_wdata_d;
      rdata_q         <= rdata_d;
      err_count_q     <= err_count_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  always_comb begin
    cpu_ready       = (state_q == IDLE);
    cpu_done        = (state_q == RESP);
    cpu_rdata       = '0;
    cpu_err         = 1'b0;
    device_select   = '0;
    read_req        = 1'b0;
    write_req       = 1'b0;
    register_offset = dec_offset;
    wdata           = req_wdata_q;
    err_count       = err_count_q;
    last_err_addr   = last_err_addr_q;
    if (state_q == ISSUE) begin
      device_select = dec_select;
      read_req      = dec_hit && !req_we_q;
      write_req     = dec_hit && req_we_q;
    end
    if (state_q == RESP) begin
      if (!dec_hit) begin
        cpu_rdata = ERR_READ_DATA;
        cpu_err   = 1'b1;
      end else if (!req_we_q) begin
        cpu_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller: driver pushes expected responses, a monitor pops them on cpu_done.
module tb_io_bus_controller;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [15:0]   cpu_addr, cpu_wdata;
  logic          cpu_ready, cpu_done, cpu_err;
  logic [15:0]   cpu_rdata;
  logic [ND-1:0] device_select;
  logic [3:0]    register_offset;
  logic          read_req, write_req;
  logic [15:0]   wdata;
  logic [16*ND-1:0] dev_rdata;
  logic [15:0]   err_count, last_err_addr;

  // Expected response: {cpu_err, cpu_rdata}
  logic [16:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  io_bus_controller #(.NUM_DEVICES(ND), .IO_BASE(16'h8000)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .device_select(device_select), .register_offset(register_offset),
    .read_req(read_req), .write_req(write_req), .wdata(wdata),
    .dev_rdata(dev_rdata), .err_count(err_count), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && cpu_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(cpu_done), 32'd0);
      end else begin
        check("response", {15'd0, cpu_err, cpu_rdata}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) check("ready_timeout", 32'(cpu_ready), 32'd1);
  endtask

  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [ND-1:0] exp_sel, input logic exp_hit,
                        input logic [16:0] exp_resp);
    @(negedge clk);
    wait_ready();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    exp_q.push_back(exp_resp);
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    check("device_select", 32'(device_select), 32'(exp_sel));
    check("register_offset", 32'(register_offset), 32'(addr[3:0]));
    check("read_req", 32'(read_req), 32'(exp_hit && !we));
    check("write_req", 32'(write_req), 32'(exp_hit && we));
    check("wdata", 32'(wdata), 32'(wd));
    check("ready_in_issue", 32'(cpu_ready), 32'd0);
    // Disturb device data after the sampling edge; the response must not see it.
    @(posedge clk);
    #1 dev_rdata = ~dev_rdata;
    @(negedge clk);
    dev_rdata = ~dev_rdata;
    @(negedge clk);
    check("done_cleared", {31'd0, cpu_done}, 32'd0);
    check("rdata_idle", {16'd0, cpu_rdata}, 32'd0);
  endtask

  initial begin
    int accepts;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev_rdata = {16'h7777, 16'hC3C3, 16'h1111, 16'hA5A5};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_sel", 32'(device_select), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_last_err", 32'(last_err_addr), 32'd0);
    check("rst_offset_wdata", {12'd0, register_offset, wdata}, 32'd0);

    access(1'b0, 16'hFFFE, 16'h0000, 4'b0001, 1'b1, {1'b0, 16'hA5A5});
    access(1'b1, 16'hFFFF, 16'h1234, 4'b0001, 1'b1, {1'b0, 16'h0000});
    access(1'b0, 16'hFFD3, 16'h0000, 4'b0100, 1'b1, {1'b0, 16'hC3C3});
    access(1'b0, 16'hFFCF, 16'h0000, 4'b1000, 1'b1, {1'b0, 16'h7777});
    check("no_err_yet", 32'(err_count), 32'd0);
    access(1'b0, 16'hF000, 16'h0000, 4'b0000, 1'b0, {1'b1, 16'hFFFF});
    check("err_count_1", 32'(err_count), 32'd1);
    check("last_err_1", 32'(last_err_addr), 32'hF000);
    access(1'b1, 16'h1234, 16'hBEEF, 4'b0000, 1'b0, {1'b1, 16'hFFFF});
    check("err_count_2", 32'(err_count), 32'd2);
    check("last_err_2", 32'(last_err_addr), 32'h1234);
    access(1'b0, 16'hFFBF, 16'h0000, 4'b0000, 1'b0, {1'b1, 16'hFFFF});
    check("err_count_3", 32'(err_count), 32'd3);
    check("last_err_3", 32'(last_err_addr), 32'hFFBF);

    // Held request for 6 cycles: accepts land 3 cycles apart.
    @(negedge clk);
    accepts = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFE0;
    for (int c = 0; c < 6; c++) begin
      if (cpu_ready) begin
        accepts++;
        exp_q.push_back({1'b0, 16'h1111});
      end
      @(negedge clk);
    end
    cpu_req = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd2);
    repeat (3) @(negedge clk);

    // Reset during ISSUE drops the access with no completion.
    wait_ready();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hF000;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    check("pre_rst_issue", 32'(cpu_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", 32'(cpu_ready), 32'd1);
    check("midrst_done", 32'(cpu_done), 32'd0);
    check("midrst_strobes", {30'd0, read_req, write_req}, 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_last_err", 32'(last_err_addr), 32'd0);
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
